// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state type, flag indices and flag-enable masks for alu_mc.
// Also provides the nibble saturating-add helper used by PADDSB.
package alu_pkg;

  localparam logic [3:0] OP_ADD    = 4'h0;
  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_XOR    = 4'h2;
  localparam logic [3:0] OP_RED    = 4'h3;
  localparam logic [3:0] OP_SLL    = 4'h4;
  localparam logic [3:0] OP_SRA    = 4'h5;
  localparam logic [3:0] OP_ROR    = 4'h6;
  localparam logic [3:0] OP_PADDSB = 4'h7;
  localparam logic [3:0] OP_LW     = 4'h8;
  localparam logic [3:0] OP_SW     = 4'h9;
  localparam logic [3:0] OP_MUL    = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } alu_state_e;

  localparam int unsigned FLG_N = 2;
  localparam int unsigned FLG_Z = 1;
  localparam int unsigned FLG_V = 0;

  localparam logic [2:0] FEN_ARITH = 3'b111;
  localparam logic [2:0] FEN_ZONLY = 3'b010;
  localparam logic [2:0] FEN_NONE  = 3'b000;
  localparam logic [2:0] FEN_MUL   = 3'b010;

  // Signed 4-bit add clamped to [-8,7]; overflow shows as bit4 != bit3 of the 5-bit sum.
  function automatic logic [3:0] sat_add4(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {a[3], a} + {b[3], b};
    if (s[4] != s[3]) return s[4] ? 4'h8 : 4'h7;
    return s[3:0];
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one conditional add per cycle over WIDTH cycles,
// producing the low WIDTH bits of i_a*i_b. o_done pulses for one cycle when finished.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_prod
);

  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [CNTW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a    <= '0;
      r_b    <= '0;
      r_acc  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else if (i_start) begin
      r_a    <= i_a;
      r_b    <= i_b;
      r_acc  <= '0;
      r_cnt  <= CNTW'(WIDTH);
      r_busy <= 1'b1;
      r_done <= 1'b0;
    end else if (r_busy) begin
      if (r_b[0]) r_acc <= r_acc + r_a;
      r_a   <= r_a << 1;
      r_b   <= r_b >> 1;
      r_cnt <= r_cnt - 1'b1;
      if (r_cnt == CNTW'(1)) begin
        r_busy <= 1'b0;
        r_done <= 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshake, registered result/flag_en and N/Z/V flag register.
// Optional iterative multiplier on opcode A when ALU_MUL_EN is defined.
module alu_mc
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       flag_en,
  output logic [2:0]       flags
);

  alu_state_e       r_state;
  alu_state_e       w_state_nx;
  logic [WIDTH-1:0] r_result;
  logic [2:0]       r_flag_en;
  logic [2:0]       r_flags;
  logic             r_v;

  logic             w_accept;
  logic             w_handoff;
  logic             w_is_mul;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic             w_mul_fin;
  logic [WIDTH-1:0] w_mul_prod;

  logic [SHW-1:0]   w_sh;
  logic [SHW:0]     w_rsh;
  logic [WIDTH-1:0] w_add;
  logic [WIDTH-1:0] w_sub;
  logic [WIDTH-1:0] w_sra;
  logic [WIDTH-1:0] w_red;
  logic [WIDTH-1:0] w_padd;
  logic             w_add_v;
  logic             w_sub_v;
  logic [WIDTH-1:0] w_res;
  logic [2:0]       w_fen;
  logic             w_v;
  logic [2:0]       w_new_flags;

  assign w_sh    = op_b[SHW-1:0];
  assign w_rsh   = (SHW+1)'(WIDTH) - {1'b0, w_sh};
  assign w_add   = op_a + op_b;
  assign w_sub   = op_a - op_b;
  assign w_sra   = $signed(op_a) >>> w_sh;
  assign w_add_v = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (w_add[WIDTH-1] != op_a[WIDTH-1]);
  assign w_sub_v = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (w_sub[WIDTH-1] != op_a[WIDTH-1]);

  always_comb begin
    w_red = '0;
    for (int unsigned i = 0; i < WIDTH / 8; i++) begin
      w_red = w_red + WIDTH'($signed(op_a[i*8 +: 8])) + WIDTH'($signed(op_b[i*8 +: 8]));
    end
  end

  always_comb begin
    w_padd = '0;
    for (int unsigned i = 0; i < WIDTH / 4; i++) begin
      w_padd[i*4 +: 4] = sat_add4(op_a[i*4 +: 4], op_b[i*4 +: 4]);
    end
  end

  always_comb begin
    w_res = op_a | op_b;
    w_fen = FEN_NONE;
    w_v   = 1'b0;
    case (opcode)
      OP_ADD:    begin w_res = w_add;  w_fen = FEN_ARITH; w_v = w_add_v; end
      OP_SUB:    begin w_res = w_sub;  w_fen = FEN_ARITH; w_v = w_sub_v; end
      OP_XOR:    begin w_res = op_a ^ op_b; w_fen = FEN_ZONLY; end
      OP_RED:    begin w_res = w_red;  w_fen = FEN_ZONLY; end
      OP_SLL:    begin w_res = op_a << w_sh; w_fen = FEN_ZONLY; end
      OP_SRA:    begin w_res = w_sra;  w_fen = FEN_ZONLY; end
      // Shifting by WIDTH yields zero, so a rotate of 0 degenerates to op_a.
      OP_ROR:    begin w_res = (op_a >> w_sh) | (op_a << w_rsh); w_fen = FEN_ZONLY; end
      OP_PADDSB: begin w_res = w_padd; w_fen = FEN_ZONLY; end
      OP_LW,
      OP_SW:     begin w_res = w_add;  w_fen = FEN_NONE; end
      default:   begin w_res = op_a | op_b; w_fen = FEN_NONE; end
    endcase
  end

`ifdef ALU_MUL_EN
  assign w_is_mul = (opcode == OP_MUL);

  alu_mul_iter #(
    .WIDTH (WIDTH)
  ) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (w_accept && w_is_mul),
    .i_a     (op_a),
    .i_b     (op_b),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_mul_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  always_comb begin
    w_state_nx = r_state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nx = w_is_mul ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        if (w_mul_done && !w_mul_busy) w_state_nx = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          if (in_valid) w_state_nx = w_is_mul ? ST_EXEC : ST_DONE;
          else          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  assign w_accept  = in_valid && in_ready;
  assign w_handoff = (r_state == ST_DONE) && out_ready;
  assign w_mul_fin = (r_state == ST_EXEC) && w_mul_done && !w_mul_busy;

  always_comb begin
    w_new_flags        = '0;
    w_new_flags[FLG_N] = r_result[WIDTH-1];
    w_new_flags[FLG_Z] = (r_result == '0);
    w_new_flags[FLG_V] = r_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Flags commit the outgoing result while a same-edge accept overwrites it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_flag_en <= FEN_NONE;
      r_v       <= 1'b0;
      r_flags   <= '0;
    end else begin
      if (w_handoff) r_flags <= (r_flags & ~r_flag_en) | (w_new_flags & r_flag_en);
      if (w_accept && !w_is_mul) begin
        r_result  <= w_res;
        r_flag_en <= w_fen;
        r_v       <= w_v;
      end else if (w_mul_fin) begin
        r_result  <= w_mul_prod;
        r_flag_en <= FEN_MUL;
        r_v       <= 1'b0;
      end
    end
  end

  assign result  = r_result;
  assign flag_en = r_flag_en;
  assign flags   = r_flags;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=16) against a behavioural arithmetic model.
// Covers the ALU_MUL_EN build when that macro is defined.
module tb_alu_mc;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [2:0]  flag_en;
  logic [2:0]  flags;

  int          checks;
  int          errors;
  logic [2:0]  exp_flags;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_en   (flag_en),
    .flags     (flags)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int to_s16(input logic [15:0] x);
    return (x >= 16'h8000) ? int'(x) - 65536 : int'(x);
  endfunction

  function automatic int sbits(input int x, input int bits);
    int m;
    m = 1 << bits;
    x = x & (m - 1);
    return (x >= m / 2) ? x - m : x;
  endfunction

  // Reference model: value, flag mask and overflow for one operation.
  function automatic void model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] r, output logic [2:0] fen, output logic v);
    int     sa, sb, s, sh;
    longint p;
    sa  = to_s16(a);
    sb  = to_s16(b);
    sh  = int'(b) % 16;
    v   = 1'b0;
    fen = 3'b000;
    r   = a | b;
    case (op)
      4'h0: begin s = sa + sb; r = 16'(s); fen = 3'b111; v = (s > 32767) || (s < -32768); end
      4'h1: begin s = sa - sb; r = 16'(s); fen = 3'b111; v = (s > 32767) || (s < -32768); end
      4'h2: begin r = a ^ b; fen = 3'b010; end
      4'h3: begin
        s = sbits(int'(a), 8) + sbits(int'(a) >> 8, 8) + sbits(int'(b), 8) + sbits(int'(b) >> 8, 8);
        r = 16'(s); fen = 3'b010;
      end
      4'h4: begin r = 16'(int'(a) * (1 << sh)); fen = 3'b010; end
      4'h5: begin s = sa >>> sh; r = 16'(s); fen = 3'b010; end
      4'h6: begin r = a; repeat (sh) r = {r[0], r[15:1]}; fen = 3'b010; end
      4'h7: begin
        for (int i = 0; i < 4; i++) begin
          s = sbits(int'(a) >> (4 * i), 4) + sbits(int'(b) >> (4 * i), 4);
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = 4'(s);
        end
        fen = 3'b010;
      end
      4'h8, 4'h9: begin r = 16'(int'(a) + int'(b)); fen = 3'b000; end
`ifdef ALU_MUL_EN
      4'hA: begin p = longint'(a) * longint'(b); r = 16'(p); fen = 3'b010; end
`endif
      default: begin r = a | b; fen = 3'b000; end
    endcase
  endfunction

  function automatic logic [2:0] upd_flags(input logic [2:0] f, input logic [15:0] r,
                                           input logic [2:0] fen, input logic v);
    logic [2:0] n;
    n = {r[15], r == 16'h0000, v};
    return (f & ~fen) | (n & fen);
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0: return 16'h7FFF;
      1: return 16'h8000;
      2: return 16'h0000;
      3: return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  // Offers one op and returns #1 after the accepting edge, with operands scrambled.
  task automatic send(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int n;
    opcode   = op;
    op_a     = a;
    op_b     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode   = 4'($urandom);
    op_a     = 16'($urandom);
    op_b     = 16'($urandom);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    opcode = 4'h0; op_a = 16'h0; op_b = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 16'h0)   begin errors++; $display("FAIL rst_result: got %h want 0000", result); end
    checks++; if (flag_en !== 3'b000) begin errors++; $display("FAIL rst_flag_en: got %b want 000", flag_en); end
    checks++; if (flags !== 3'b000)   begin errors++; $display("FAIL rst_flags: got %b want 000", flags); end
    rst_n = 1'b1;
    exp_flags = 3'b000;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] r;
    logic [2:0]  fen;
    logic [2:0]  flg;
  } vec_t;

  task automatic test_directed();
    vec_t        tbl[13];
    logic [15:0] mr;
    logic [2:0]  mf;
    logic        mv;
    tbl[0]  = '{4'h1, 16'h1234, 16'h1234, 16'h0000, 3'b111, 3'b010};
    tbl[1]  = '{4'h0, 16'h7FFF, 16'h0001, 16'h8000, 3'b111, 3'b101};
    tbl[2]  = '{4'h2, 16'h00FF, 16'h00FF, 16'h0000, 3'b010, 3'b111};
    tbl[3]  = '{4'h5, 16'h8000, 16'h0004, 16'hF800, 3'b010, 3'b101};
    tbl[4]  = '{4'h6, 16'h0001, 16'h0001, 16'h8000, 3'b010, 3'b101};
    tbl[5]  = '{4'h7, 16'h7181, 16'h1F8F, 16'h7080, 3'b010, 3'b101};
    tbl[6]  = '{4'h3, 16'h0102, 16'h0304, 16'h000A, 3'b010, 3'b101};
    tbl[7]  = '{4'h8, 16'h0100, 16'h0020, 16'h0120, 3'b000, 3'b101};
    tbl[8]  = '{4'h4, 16'h0003, 16'h0004, 16'h0030, 3'b010, 3'b101};
    tbl[9]  = '{4'hF, 16'h00F0, 16'h0F00, 16'h0FF0, 3'b000, 3'b101};
    tbl[10] = '{4'h9, 16'hFFFF, 16'h0001, 16'h0000, 3'b000, 3'b101};
    tbl[11] = '{4'h1, 16'h8000, 16'h0001, 16'h7FFF, 3'b111, 3'b001};
    tbl[12] = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000, 3'b111, 3'b010};
    out_ready = 1'b1;
    foreach (tbl[i]) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL dir%0d_valid: got %b want 1", i, out_valid); end
      checks++; if (result !== tbl[i].r) begin errors++; $display("FAIL dir%0d_result: got %h want %h", i, result, tbl[i].r); end
      checks++; if (flag_en !== tbl[i].fen) begin errors++; $display("FAIL dir%0d_flag_en: got %b want %b", i, flag_en, tbl[i].fen); end
      @(posedge clk); #1;
      checks++; if (flags !== tbl[i].flg) begin errors++; $display("FAIL dir%0d_flags: got %b want %b", i, flags, tbl[i].flg); end
      model(tbl[i].op, tbl[i].a, tbl[i].b, mr, mf, mv);
      exp_flags = upd_flags(exp_flags, mr, mf, mv);
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_opcode_a();
    int n;
    out_ready = 1'b1;
    send(4'hA, 16'h0012, 16'h0034);
    n = 1;
    while (!out_valid && n < 64) begin
      @(posedge clk); #1;
      n++;
    end
    checks++; if (n != 17) begin errors++; $display("FAIL mul_latency: got %0d edges want 17", n); end
    checks++; if (result !== 16'h03A8) begin errors++; $display("FAIL mul_result: got %h want 03a8", result); end
    checks++; if (flag_en !== 3'b010) begin errors++; $display("FAIL mul_flag_en: got %b want 010", flag_en); end
    @(posedge clk); #1;
    exp_flags = upd_flags(exp_flags, 16'h03A8, 3'b010, 1'b0);
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL mul_flags: got %b want %b", flags, exp_flags); end
    send(4'hA, 16'h1234, 16'h5678);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mulrst_valid: got %b want 0", out_valid); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL mulrst_flags: got %b want 000", flags); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_flags = 3'b000;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mulrst_late_valid: got %b want 0", out_valid); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL mulrst_late_flags: got %b want 000", flags); end
  endtask
`else
  task automatic test_opcode_a();
    out_ready = 1'b1;
    send(4'hA, 16'h0012, 16'h0034);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL opa_valid: got %b want 1", out_valid); end
    checks++; if (result !== 16'h0036) begin errors++; $display("FAIL opa_result: got %h want 0036", result); end
    checks++; if (flag_en !== 3'b000) begin errors++; $display("FAIL opa_flag_en: got %b want 000", flag_en); end
    @(posedge clk); #1;
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL opa_flags: got %b want %b", flags, exp_flags); end
  endtask
`endif

  task automatic test_random();
    logic [3:0]  op;
    logic [15:0] a, b, mr;
    logic [2:0]  mf;
    logic        mv;
    int          n;
    for (int k = 0; k < 60; k++) begin
      op = 4'($urandom_range(0, 15));
      a  = pick();
      b  = pick();
      model(op, a, b, mr, mf, mv);
      out_ready = 1'b0;
      send(op, a, b);
      n = 0;
      while (!out_valid && n < 64) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (!out_valid) begin
        errors++; $display("FAIL rnd%0d_timeout: out_valid=%b required 1", k, out_valid);
      end else if (result !== mr || flag_en !== mf) begin
        errors++; $display("FAIL rnd%0d_op%h: got %h/%b want %h/%b", k, op, result, flag_en, mr, mf);
      end
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        checks++; if (result !== mr) begin errors++; $display("FAIL rnd%0d_hold: got %h want %h", k, result, mr); end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      exp_flags = upd_flags(exp_flags, mr, mf, mv);
      checks++; if (flags !== exp_flags) begin errors++; $display("FAIL rnd%0d_flags: got %b want %b", k, flags, exp_flags); end
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] mr;
    logic [2:0]  mf;
    logic        mv;
    out_ready = 1'b0;
    send(4'h0, 16'h0003, 16'h0004);
    for (int k = 0; k < 5; k++) begin
      op_a = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || result !== 16'h0007 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d: got v=%b r=%h rdy=%b want 1/0007/0", k, out_valid, result, in_ready);
      end
    end
    exp_flags = upd_flags(exp_flags, 16'h0007, 3'b111, 1'b0);
    opcode = 4'h2; op_a = 16'hF0F0; op_b = 16'h0F0F;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (result !== 16'hFFFF || flag_en !== 3'b010) begin errors++; $display("FAIL bp_new: got %h/%b want ffff/010", result, flag_en); end
    checks++; if (flags !== exp_flags) begin errors++; $display("FAIL bp_old_flags: got %b want %b", flags, exp_flags); end
    model(4'h2, 16'hF0F0, 16'h0F0F, mr, mf, mv);
    @(posedge clk); #1;
    exp_flags = upd_flags(exp_flags, mr, mf, mv);
    checks++; if (flags !== exp_flags || out_valid !== 1'b0) begin errors++; $display("FAIL bp_new_flags: got %b/%b want %b/0", flags, out_valid, exp_flags); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[20];
    logic [15:0] ra[20], rb[20], mr[20];
    logic [2:0]  mf[20];
    logic        mv[20];
    for (int i = 0; i < 20; i++) begin
      ops[i] = 4'($urandom_range(0, 15));
`ifdef ALU_MUL_EN
      if (ops[i] == 4'hA) ops[i] = 4'h1;
`endif
      ra[i] = pick();
      rb[i] = pick();
      model(ops[i], ra[i], rb[i], mr[i], mf[i], mv[i]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      opcode = ops[i]; op_a = ra[i]; op_b = rb[i]; in_valid = 1'b1;
      @(posedge clk); #1;
      if (i > 0) exp_flags = upd_flags(exp_flags, mr[i-1], mf[i-1], mv[i-1]);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || result !== mr[i] || flag_en !== mf[i]) begin
        errors++; $display("FAIL b2b%0d: got v=%b rdy=%b %h/%b want 1/1 %h/%b", i, out_valid, in_ready, result, flag_en, mr[i], mf[i]);
      end
      checks++; if (flags !== exp_flags) begin errors++; $display("FAIL b2b%0d_flags: got %b want %b", i, flags, exp_flags); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    exp_flags = upd_flags(exp_flags, mr[19], mf[19], mv[19]);
    checks++; if (flags !== exp_flags || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b/%b want %b/0", flags, out_valid, exp_flags); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_flags = 3'b000;
    test_reset();
    test_directed();
    test_opcode_a();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Multi-cycle, parametrised successor to the single-cycle ALU of the WISC-F23 datapath. It accepts one operation per valid/ready handshake and registers the result and its flag-enable mask. It holds an architectural N/Z/V flag register, updated on result handoff under that mask, and can add an optional iterative multiplier. It sits between decode/register-read and writeback in the multi-cycle core.

## Interface
- WIDTH, 16, datapath width; multiple of 8, ≥ 8
- SHW, $clog2(WIDTH), shift-amount width (derived)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  operation can be accepted this cycle
- opcode  in  4  operation select
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B; shifts use op_b[SHW-1:0]
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- result  out  WIDTH  registered result
- flag_en  out  3  per-flag update mask of the current result, {N,Z,V}
- flags  out  3  architectural flag register {N,Z,V}

## Operation
- Opcodes:
  - 0 ADD: wrapping sum; flag_en 111.
  - 1 SUB: A−B; flag_en 111.
  - 2 XOR; flag_en 010.
  - 3 RED: signed sum of every byte of A and B, sign-extended to WIDTH; flag_en 010.
  - 4 SLL, 5 SRA, 6 ROR: applied to A; flag_en 010.
  - 7 PADDSB: per-nibble signed saturating add, clamped to [−8,7]; flag_en 010.
  - 8/9 LW/SW address: A+B; flag_en 000.
  - A MUL: only when configured (see Configuration); flag_en 010.
  - Any other opcode: A|B; flag_en 000.
- Flag rules:
  - V is set on signed overflow of ADD/SUB.
  - N = result[WIDTH-1].
  - Z = (result == 0).
- States: IDLE, EXEC, DONE.
  - IDLE: in_ready=1. On accept (in_valid&&in_ready):
    - single-cycle op → compute and register, go to DONE;
    - MUL → go to EXEC.
  - EXEC: iterate the multiplier; after the last iteration go to DONE.
  - DONE: out_valid=1. result and flag_en are held stable until out_ready.
- Handoff (DONE && out_ready): flags[i] ← new flag value where flag_en[i]=1; other bits unchanged.
- in_ready = IDLE || (DONE && out_ready). When a new op is accepted in the handoff cycle, the next state follows the new op; flags update for the old result on the same edge.
- Operands are captured on accept. Later changes to op_a/op_b/opcode have no effect.

## Timing
- Reset (async assert): state IDLE, in_ready=1, out_valid=0, result=0, flag_en=000, flags=000.
- Reset asserted mid-EXEC aborts the op; no result and no flag update.
- Single-cycle ops: accept on edge k, out_valid high from edge k onward (latency 1).
- MUL: out_valid rises WIDTH+1 edges after accept.
- Flags become visible the cycle after the handoff edge.
- Sustained throughput with out_ready held at 1: one single-cycle op per clock.
- Combinational paths: in_ready depends on out_ready only. No combinational path from in_valid to outputs.

## Configuration
- ALU_MUL_EN defined: opcode A is an unsigned shift-add multiply producing the low WIDTH bits of A×B.
  - Uses one add per cycle over WIDTH EXEC cycles.
  - Flag rule: flag_en 010, Z only.
- ALU_MUL_EN undefined: opcode A takes the default path (A|B, flag_en 000). The EXEC state is unreachable and no multiplier logic is synthesised.

## Structure
- Package alu_pkg holds:
  - opcode localparams;
  - the IDLE/EXEC/DONE state enum;
  - flag bit indices (N=2, Z=1, V=0);
  - per-opcode flag_en constants.
- Sub-module alu_mul_iter: iterative multiplier with start/busy/done, WIDTH-parametrised. Instantiated only under ALU_MUL_EN.

## Test plan
- ADD 0x7FFF+0x0001, out_ready=1 → result 0x8000, flag_en 111; flags 101 the cycle after handoff.
- SUB 0x1234−0x1234 → 0x0000, flags 010; then XOR 0x00FF^0x00FF with prior flags 101 → flags 111 (N,V kept).
- SRA 0x8000 by 4 → 0xF800; ROR 0x0001 by 1 → 0x8000; PADDSB 0x7181+0x1F8F → 0x7080; RED 0x0102,0x0304 → 0x000A.
- Opcode 8 address add 0x0100+0x0020 → 0x0120, flag_en 000, flags unchanged. Back-to-back single-cycle ops with out_ready=1 → one result per clock.
- Backpressure: hold out_ready=0 for 5 cycles → result stable, in_ready=0. Then raise out_ready and in_valid together → old result handed off and new op accepted on the same edge.
- ALU_MUL_EN: MUL 0x0012×0x0034 → 0x03A8 with out_valid exactly 17 edges after accept. Reset mid-EXEC → out_valid stays 0, flags 000. Without ALU_MUL_EN: opcode A, 0x0012,0x0034 → 0x0036 after 1 cycle.
